// File: rtl/log_trace_buffer.sv
// Multi-channel leveled log capture: severity filter, round-robin arbiter, timestamped FWFT ring buffer.
// Optional macro LOG_TRACE_OVERWRITE_EN: a full buffer overwrites its oldest entry instead of stalling.
module log_trace_buffer #(
    parameter int NUM_CH = 4,
    parameter int MSG_W  = 32,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 32
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_CH-1:0]                             ev_valid,
    output logic [NUM_CH-1:0]                             ev_ready,
    input  logic [3*NUM_CH-1:0]                           ev_level,
    input  logic [MSG_W*NUM_CH-1:0]                       ev_msg,
    input  logic [2:0]                                    min_level,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0]  out_ch,
    output logic [2:0]                                    out_level,
    output logic [MSG_W-1:0]                              out_msg,
    output logic [TS_W-1:0]                               out_ts,
    output logic [$clog2(DEPTH):0]                        count,
    output logic [15:0]                                   drop_cnt,
    output logic                                          fatal_seen
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [TS_W-1:0]  ts;
    logic [CH_W-1:0]  rr_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [CH_W-1:0]  mem_ch  [DEPTH];
    logic [2:0]       mem_lvl [DEPTH];
    logic [MSG_W-1:0] mem_msg [DEPTH];
    logic [TS_W-1:0]  mem_ts  [DEPTH];

    logic [NUM_CH-1:0] cand;
    logic [NUM_CH-1:0] filtered;
    logic              grant_valid;
    logic [CH_W-1:0]   grant_idx;
    logic [2:0]        grant_lvl;
    logic [MSG_W-1:0]  grant_msg;
    logic              full;
    logic              pop;
    logic              can_accept;
    logic              push;
    logic              overwrite;

    function automatic logic [CH_W-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return s[CH_W-1:0];
    endfunction

    // FATAL levels bypass the threshold; everything else valid but below it is consumed and dropped
    always_comb begin
        cand     = '0;
        filtered = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand[i]     = ev_valid[i] && ((ev_level[i*3 +: 3] >= min_level) || (ev_level[i*3 +: 3] >= 3'd5));
            filtered[i] = ev_valid[i] && !cand[i];
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!grant_valid && cand[wrap_idx(32'(rr_ptr), k)]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap_idx(32'(rr_ptr), k);
            end
        end
    end

    assign grant_lvl = ev_level[32'(grant_idx)*3 +: 3];
    assign grant_msg = ev_msg[32'(grant_idx)*MSG_W +: MSG_W];

    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

`ifdef LOG_TRACE_OVERWRITE_EN
    assign can_accept = 1'b1;
    assign overwrite  = push && full && !pop;
`else
    assign can_accept = !full || pop;
    assign overwrite  = 1'b0;
`endif

    assign push = grant_valid && can_accept && !rst;

    always_comb begin
        ev_ready = '0;
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++)
                ev_ready[i] = filtered[i] || (push && (grant_idx == CH_W'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_ch[wr_ptr]  <= grant_idx;
            mem_lvl[wr_ptr] <= grant_lvl;
            mem_msg[wr_ptr] <= grant_msg;
            mem_ts[wr_ptr]  <= ts;
        end
    end

    // An overwrite advances the read pointer so the oldest entry is the one lost
    always_ff @(posedge clk) begin
        if (rst) begin
            ts         <= '0;
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_cnt   <= '0;
            fatal_seen <= 1'b0;
        end else begin
            ts <= ts + 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= wrap_idx(32'(grant_idx), 1);
                if (grant_lvl >= 3'd5) fatal_seen <= 1'b1;
            end
            if (pop || overwrite) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop && !overwrite) count <= count + 1'b1;
            else if (pop && !push)          count <= count - 1'b1;
            if (overwrite && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign out_ch    = mem_ch[rd_ptr];
    assign out_level = mem_lvl[rd_ptr];
    assign out_msg   = mem_msg[rd_ptr];
    assign out_ts    = mem_ts[rd_ptr];

endmodule

// File: tb/tb_log_trace_buffer.sv
// Directed self-checking bench for log_trace_buffer (default parameters).
// Expectations for the full-buffer case follow LOG_TRACE_OVERWRITE_EN when it is defined.
module tb_log_trace_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   ev_valid;
    logic [3:0]   ev_ready;
    logic [11:0]  ev_level;
    logic [127:0] ev_msg;
    logic [2:0]   min_level;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_ch;
    logic [2:0]   out_level;
    logic [31:0]  out_msg;
    logic [31:0]  out_ts;
    logic [4:0]   count;
    logic [15:0]  drop_cnt;
    logic         fatal_seen;

    int testsRun  = 0;
    int testsFail = 0;

    log_trace_buffer dut (
        .clk(clk), .rst(rst),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_level(ev_level), .ev_msg(ev_msg),
        .min_level(min_level),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_level(out_level), .out_msg(out_msg), .out_ts(out_ts),
        .count(count), .drop_cnt(drop_cnt), .fatal_seen(fatal_seen)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic valid, input logic [2:0] lvl, input logic [31:0] msg);
        ev_valid[ch]         = valid;
        ev_level[ch*3 +: 3]  = lvl;
        ev_msg[ch*32 +: 32]  = msg;
    endtask

    // Advance past the next rising edge and sample one step later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        ev_valid  = 4'hF;
        ev_level  = 12'hFFF;
        ev_msg    = '0;
        min_level = 3'd0;
        out_ready = 1'b0;
        #1;
        checkOutput("ready_in_reset", 64'(ev_ready), 64'h0);
        step();
        step();
        rst      = 1'b0;
        ev_valid = 4'h0;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'h0);
        checkOutput("rst_count", 64'(count), 64'h0);
        checkOutput("rst_drop", 64'(drop_cnt), 64'h0);
        checkOutput("rst_fatal", 64'(fatal_seen), 64'h0);

        // single INFO event at cycle 10
        min_level = 3'd2;
        repeat (10) step();
        applyStimulus(1, 1'b1, 3'd2, 32'hA5);
        #1;
        checkOutput("t1_ready", 64'(ev_ready), 64'h2);
        checkOutput("t1_empty", 64'(out_valid), 64'h0);
        step();
        applyStimulus(1, 1'b0, 3'd0, 32'h0);
        #1;
        checkOutput("t1_valid", 64'(out_valid), 64'h1);
        checkOutput("t1_ch", 64'(out_ch), 64'h1);
        checkOutput("t1_level", 64'(out_level), 64'h2);
        checkOutput("t1_msg", 64'(out_msg), 64'hA5);
        checkOutput("t1_ts", 64'(out_ts), 64'd10);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        checkOutput("t1_drained", 64'(count), 64'h0);

        // threshold filtering and FATAL bypass
        min_level = 3'd3;
        applyStimulus(0, 1'b1, 3'd1, 32'h11);
        applyStimulus(2, 1'b1, 3'd5, 32'h22);
        #1;
        checkOutput("t2_ready_a", 64'(ev_ready), 64'h5);
        checkOutput("t2_fatal_pre", 64'(fatal_seen), 64'h0);
        step();
        applyStimulus(0, 1'b0, 3'd0, 32'h0);
        applyStimulus(2, 1'b0, 3'd0, 32'h0);
        #1;
        checkOutput("t2_fatal_post", 64'(fatal_seen), 64'h1);
        checkOutput("t2_count_a", 64'(count), 64'h1);
        checkOutput("t2_head_ch", 64'(out_ch), 64'h2);
        checkOutput("t2_head_msg", 64'(out_msg), 64'h22);
        min_level = 3'd7;
        applyStimulus(3, 1'b1, 3'd6, 32'h33);
        applyStimulus(1, 1'b1, 3'd4, 32'h44);
        #1;
        checkOutput("t2_ready_b", 64'(ev_ready), 64'hA);
        step();
        applyStimulus(3, 1'b0, 3'd0, 32'h0);
        applyStimulus(1, 1'b0, 3'd0, 32'h0);
        out_ready = 1'b1;
        #1;
        checkOutput("t2_count_b", 64'(count), 64'h2);
        step();
        checkOutput("t2_second_lvl", 64'(out_level), 64'h6);
        checkOutput("t2_second_msg", 64'(out_msg), 64'h33);
        step();
        checkOutput("t2_drained", 64'(count), 64'h0);

        // round-robin with all channels busy
        min_level = 3'd0;
        for (int c = 0; c < 4; c++) applyStimulus(c, 1'b1, 3'd2, 32'h200 + 32'(c));
        #1;
        for (int k = 0; k < 5; k++) begin
            checkOutput("t3_grant", 64'(ev_ready), 64'(4'b0001 << (k % 4)));
            step();
            checkOutput("t3_head_ch", 64'(out_ch), 64'(k % 4));
            checkOutput("t3_count", 64'(count), 64'h1);
        end
        ev_valid = 4'h0;
        step();
        out_ready = 1'b0;
        #1;
        checkOutput("t3_drained", 64'(count), 64'h0);

        // fill to DEPTH, then one more
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 1'b1, 3'd2, 32'h100 + 32'(i));
            #1;
            checkOutput("t4_fill_ready", 64'(ev_ready), 64'h2);
            step();
        end
        checkOutput("t4_full", 64'(count), 64'd16);
        applyStimulus(1, 1'b1, 3'd2, 32'h110);
        #1;
`ifdef LOG_TRACE_OVERWRITE_EN
        checkOutput("t4_ovr_ready", 64'(ev_ready), 64'h2);
        step();
        applyStimulus(1, 1'b0, 3'd0, 32'h0);
        #1;
        checkOutput("t4_ovr_count", 64'(count), 64'd16);
        checkOutput("t4_ovr_drop", 64'(drop_cnt), 64'h1);
        checkOutput("t4_ovr_head", 64'(out_msg), 64'h101);
`else
        checkOutput("t4_stall_ready", 64'(ev_ready), 64'h0);
        step();
        checkOutput("t4_stall_hold", 64'(ev_ready), 64'h0);
        checkOutput("t4_stall_count", 64'(count), 64'd16);
        checkOutput("t4_stall_head", 64'(out_msg), 64'h100);
        out_ready = 1'b1;
        #1;
        checkOutput("t4_pop_ready", 64'(ev_ready), 64'h2);
        step();
        applyStimulus(1, 1'b0, 3'd0, 32'h0);
        out_ready = 1'b0;
        #1;
        checkOutput("t4_after_count", 64'(count), 64'd16);
        checkOutput("t4_after_head", 64'(out_msg), 64'h101);
        checkOutput("t4_drop", 64'(drop_cnt), 64'h0);
`endif

        // reset mid-operation
        out_ready = 1'b1;
        repeat (11) step();
        out_ready = 1'b0;
        #1;
        checkOutput("t5_count5", 64'(count), 64'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checkOutput("t5_valid", 64'(out_valid), 64'h0);
        checkOutput("t5_count", 64'(count), 64'h0);
        checkOutput("t5_fatal", 64'(fatal_seen), 64'h0);
        checkOutput("t5_drop", 64'(drop_cnt), 64'h0);
        applyStimulus(0, 1'b1, 3'd0, 32'h77);
        #1;
        checkOutput("t5_ready", 64'(ev_ready), 64'h1);
        step();
        applyStimulus(0, 1'b0, 3'd0, 32'h0);
        #1;
        checkOutput("t5_ts", 64'(out_ts), 64'h0);
        checkOutput("t5_msg", 64'(out_msg), 64'h77);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule

// File: doc/log_trace_buffer.md
# log_trace_buffer

Multi-channel hardware log capture buffer; the parametrised successor to the simulation-only logging package. It accepts leveled log events from NUM_CH producer channels and filters them against a runtime severity threshold. Events that pass are timestamped, arbitrated round-robin and stored in a DEPTH-entry ring buffer. A single ready/valid drain port reads them out. It sits between instrumented RTL blocks and a debug/trace sink, such as a UART dumper or a bench monitor that prints with the log colour scheme.

## Interface
Parameters:
- NUM_CH, 4, number of producer channels (1..16)
- MSG_W, 32, message payload width
- DEPTH, 16, buffer entries; power of two, >= 2
- TS_W, 32, timestamp width

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- ev_valid  in  NUM_CH  per-channel event valid
- ev_ready  out  NUM_CH  per-channel event accepted/consumed
- ev_level  in  3*NUM_CH  per-channel level: 0 VERBOSE, 1 DEBUG, 2 INFO, 3 WARN, 4 ERROR, 5..7 FATAL
- ev_msg  in  MSG_W*NUM_CH  per-channel payload
- min_level  in  3  runtime threshold; sampled each cycle
- out_valid  out  1  buffer non-empty
- out_ready  in  1  sink accepts head entry
- out_ch  out  $clog2(NUM_CH) (min 1)  source channel of head
- out_level  out  3  level of head
- out_msg  out  MSG_W  payload of head
- out_ts  out  TS_W  timestamp of head
- count  out  $clog2(DEPTH)+1  occupancy
- drop_cnt  out  16  saturating count of overwritten entries
- fatal_seen  out  1  sticky: a FATAL event was stored

## Operation
- Timestamp counter ts: 0 after reset, +1 every cycle, wraps modulo 2^TS_W.
- A channel is a candidate when ev_valid=1 and either ev_level>=min_level or ev_level>=5. FATAL always passes.
- Filtered channels (valid, below threshold, not FATAL) get ev_ready=1 in the same cycle. They are discarded and not stored.
- Arbiter: at most one candidate stored per cycle. Grant goes to the first candidate at or after rr_ptr, scanning upward and wrapping. After a grant, rr_ptr = (granted+1) mod NUM_CH; with no grant it is unchanged.
- ev_ready for a candidate = granted AND (buffer can accept). Non-granted candidates see ev_ready=0 and must hold valid/level/msg stable.
- A stored entry holds {channel, level, msg, ts at acceptance cycle}.
- The buffer is first-word-fall-through. out_* reflect the head entry whenever out_valid=1. out_ch/out_level/out_msg/out_ts are don't-care when out_valid=0.
- Pop on out_valid & out_ready.
- Can-accept: count<DEPTH, or a pop in the same cycle, or the overwrite mode (see Configuration).
- Full buffer with simultaneous pop and push: both occur, count stays DEPTH, no drop.
- fatal_seen is set on the cycle after storing any entry with level>=5. It is cleared only by rst.
- drop_cnt saturates at 16'hFFFF.

## Timing
- Reset values: ev_ready=0, out_valid=0, count=0, drop_cnt=0, fatal_seen=0, ts=0, rr_ptr=0. Both buffer pointers are 0.
- ev_ready is combinational from ev_valid, ev_level, min_level, rr_ptr, count and out_ready.
- ev_ready is forced 0 while rst=1.
- Latency: an event accepted at edge N gives out_valid=1 and the head entry at N+1 if the buffer was empty. Throughput is 1 event/cycle in and 1 out.
- Reset asserted mid-operation discards all contents at that edge. Producer handshakes in the rst cycle do not complete.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.

## Configuration
- LOG_TRACE_OVERWRITE_EN defined: the buffer never back-pressures a granted candidate.
  - When full and no pop, the push overwrites the oldest entry: rd_ptr advances, count stays DEPTH, drop_cnt increments.
  - The head becomes the next-oldest entry on the following cycle.
- Not defined: a full buffer with no pop gives the granted channel ev_ready=0. rr_ptr does not advance on such a stalled grant. drop_cnt stays 0.

## Test plan
- Reset, min_level=2; ch1 sends INFO msg 0xA5 at cycle 10 -> ev_ready[1]=1 at cycle 10; out_valid at 11 with out_ch=1, out_level=2, out_msg=0xA5, out_ts=10.
- min_level=3; ch0 DEBUG and ch2 FATAL in the same cycle, min_level=7 on a later FATAL -> DEBUG consumed and not stored; both FATALs stored; fatal_seen=1 one cycle after the first.
- All 4 channels valid continuously, out_ready=1 -> grants in order 0,1,2,3,0; each channel gets one accept per 4 cycles.
- out_ready=0, 17 events with DEPTH=16, macro undefined -> count=16, the 17th waits with ev_ready=0; after one pop it is stored, drop_cnt=0.
- Same stimulus with LOG_TRACE_OVERWRITE_EN -> count=16, drop_cnt=1; the drained head is the 2nd event.
- rst asserted with count=5 -> next cycle out_valid=0, count=0, ts=0, fatal_seen=0.
